fan_ramp_ctrl: RTL and testbench

FAN_RAMP_CTRL -- requirements
Module: fan_ramp_ctrl

---
 rtl/fan_pkg.sv | 41 ++++
 rtl/fan_off_timer.sv | 80 ++++++++
 rtl/fan_ramp_ctrl.sv | 142 ++++++++++++++
 tb/tb_fan_ramp_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Shared types and default constants for the fan ramp controller and its off-timer.
// Level, timer preset and FSM encodings live here so both modules agree on them.
package fan_pkg;

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_MID  = 2'd2,
    LVL_HIGH = 2'd3
  } level_e;

  typedef enum logic [1:0] {
    TMR_NONE = 2'd0,
    TMR_T1   = 2'd1,
    TMR_T2   = 2'd2,
    TMR_T3   = 2'd3
  } timer_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int DEF_DUTY_LOW  = 25;
  localparam int DEF_DUTY_MID  = 50;
  localparam int DEF_DUTY_HIGH = 75;
  localparam int DEF_T1_S      = 60;
  localparam int DEF_T2_S      = 180;
  localparam int DEF_T3_S      = 300;

  // Both selectors wrap around after their last value.
  function automatic level_e nextLevel(level_e lvl);
    return level_e'(lvl + 2'd1);
  endfunction

  function automatic timer_sel_e nextTimer(timer_sel_e sel);
    return timer_sel_e'(sel + 2'd1);
  endfunction

endpackage

// File: rtl/fan_off_timer.sv
// Off-timer: preset selection, seconds prescaler on the 1 ms tick and a
// remaining-seconds counter that pulses expire_o on the 1 -> 0 transition.
module fan_off_timer
  import fan_pkg::*;
#(
  parameter int TICKS_PER_S = 1000,
  parameter int T1_S        = DEF_T1_S,
  parameter int T2_S        = DEF_T2_S,
  parameter int T3_S        = DEF_T3_S
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_i,
  input  logic       advance_i,
  input  logic       clear_i,
  output logic [1:0] timer_sel_o,
  output logic [8:0] remaining_s_o,
  output logic       expire_o
);

  localparam int SW = (TICKS_PER_S > 1) ? $clog2(TICKS_PER_S) : 1;

  timer_sel_e    sel_q, sel_d;
  logic [8:0]    rem_q, rem_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          secDone;
  logic          expire;

  function automatic logic [8:0] presetOf(timer_sel_e sel);
    case (sel)
      TMR_T1:  return 9'(T1_S);
      TMR_T2:  return 9'(T2_S);
      TMR_T3:  return 9'(T3_S);
      default: return 9'd0;
    endcase
  endfunction

  assign secDone = tick_i && (sel_q != TMR_NONE) && (sec_q == SW'(TICKS_PER_S - 1));
  assign expire  = secDone && (rem_q <= 9'd1);

  // Expiry and clear win over a preset press; a preset load restarts the second.
  always_comb begin
    sel_d = sel_q;
    rem_d = rem_q;
    sec_d = sec_q;
    if (clear_i || expire) begin
      sel_d = TMR_NONE;
      rem_d = 9'd0;
      sec_d = '0;
    end else if (advance_i) begin
      sel_d = nextTimer(sel_q);
      rem_d = presetOf(nextTimer(sel_q));
      sec_d = '0;
    end else if (tick_i && (sel_q != TMR_NONE)) begin
      if (secDone) begin
        sec_d = '0;
        rem_d = rem_q - 9'd1;
      end else begin
        sec_d = sec_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q <= TMR_NONE;
      rem_q <= 9'd0;
      sec_q <= '0;
    end else begin
      sel_q <= sel_d;
      rem_q <= rem_d;
      sec_q <= sec_d;
    end
  end

  assign timer_sel_o   = sel_q;
  assign remaining_s_o = rem_q;
  assign expire_o      = expire;

endmodule

// File: rtl/fan_ramp_ctrl.sv
// Fan speed controller: button-selected level, duty ramped one step per
// RAMP_MS ticks toward the level target, with an optional auto-off timer.
module fan_ramp_ctrl
  import fan_pkg::*;
#(
  parameter int RAMP_MS     = 4,
  parameter int TICKS_PER_S = 1000,
  parameter int DUTY_LOW    = DEF_DUTY_LOW,
  parameter int DUTY_MID    = DEF_DUTY_MID,
  parameter int DUTY_HIGH   = DEF_DUTY_HIGH,
  parameter int T1_S        = DEF_T1_S,
  parameter int T2_S        = DEF_T2_S,
  parameter int T3_S        = DEF_T3_S
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1ms,
  input  logic       btn_level_pe,
  input  logic       btn_timer_pe,
  output logic [6:0] duty,
  output logic [1:0] level,
  output logic [1:0] timer_sel,
  output logic [8:0] remaining_s,
  output logic       ramping
);

  localparam int RW = (RAMP_MS > 1) ? $clog2(RAMP_MS) : 1;

  level_e        level_q, level_d, levelByBtn;
  state_e        state_q;
  logic [6:0]    duty_q;
  logic [6:0]    targetNext;
  logic [6:0]    dutyStep;
  logic [RW-1:0] rampCnt_q;
  logic          ramping_q;
  logic          stepNow;
  logic          expire;
  logic          timerAdvance;
  logic          timerClear;

  function automatic logic [6:0] targetOf(level_e lvl);
    case (lvl)
      LVL_LOW:  return 7'(DUTY_LOW);
      LVL_MID:  return 7'(DUTY_MID);
      LVL_HIGH: return 7'(DUTY_HIGH);
      default:  return 7'd0;
    endcase
  endfunction

  function automatic state_e settleState(logic [6:0] tgt);
    return (tgt == 7'd0) ? ST_IDLE : ST_HOLD;
  endfunction

  // Expiry beats a coincident level press; a level press swallows a timer press.
  always_comb begin
    levelByBtn   = nextLevel(level_q);
    level_d      = level_q;
    if (expire) begin
      level_d = LVL_OFF;
    end else if (btn_level_pe) begin
      level_d = levelByBtn;
    end
    timerAdvance = btn_timer_pe && !btn_level_pe && (level_q != LVL_OFF);
    timerClear   = btn_level_pe && (levelByBtn == LVL_OFF);
    targetNext   = targetOf(level_d);
    dutyStep     = (targetNext > duty_q) ? duty_q + 7'd1 : duty_q - 7'd1;
    stepNow      = tick_1ms && (rampCnt_q == RW'(RAMP_MS - 1));
  end

  fan_off_timer #(
    .TICKS_PER_S (TICKS_PER_S),
    .T1_S        (T1_S),
    .T2_S        (T2_S),
    .T3_S        (T3_S)
  ) u_off_timer (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick_i        (tick_1ms),
    .advance_i     (timerAdvance),
    .clear_i       (timerClear),
    .timer_sel_o   (timer_sel),
    .remaining_s_o (remaining_s),
    .expire_o      (expire)
  );

  // A target change restarts the step prescaler but keeps the current duty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q   <= LVL_OFF;
      state_q   <= ST_IDLE;
      duty_q    <= 7'd0;
      rampCnt_q <= '0;
      ramping_q <= 1'b0;
    end else begin
      level_q <= level_d;
      if (level_d != level_q) begin
        rampCnt_q <= '0;
        if (duty_q != targetNext) begin
          state_q   <= ST_RAMP;
          ramping_q <= 1'b1;
        end else begin
          state_q   <= settleState(targetNext);
          ramping_q <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_IDLE, ST_HOLD: begin
            if (duty_q != targetNext) begin
              state_q   <= ST_RAMP;
              ramping_q <= 1'b1;
              rampCnt_q <= '0;
            end
          end
          ST_RAMP: begin
            if (duty_q == targetNext) begin
              state_q   <= settleState(targetNext);
              ramping_q <= 1'b0;
            end else if (stepNow) begin
              duty_q    <= dutyStep;
              rampCnt_q <= '0;
              if (dutyStep == targetNext) begin
                state_q   <= settleState(targetNext);
                ramping_q <= 1'b0;
              end
            end else if (tick_1ms) begin
              rampCnt_q <= rampCnt_q + RW'(1);
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            ramping_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign duty    = duty_q;
  assign level   = level_q;
  assign ramping = ramping_q;

endmodule

// File: tb/tb_fan_ramp_ctrl.sv
// Directed self-checking bench for fan_ramp_ctrl with a shortened 10-tick second
// and a 3 s first preset so the auto-off path finishes quickly.
module tb_fan_ramp_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       tick_1ms = 1'b0;
  logic       btn_level_pe = 1'b0;
  logic       btn_timer_pe = 1'b0;
  logic [6:0] duty;
  logic [1:0] level;
  logic [1:0] timer_sel;
  logic [8:0] remaining_s;
  logic       ramping;

  int assertCount = 0;
  int failCount   = 0;

  fan_ramp_ctrl #(
    .RAMP_MS     (4),
    .TICKS_PER_S (10),
    .T1_S        (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick_1ms     (tick_1ms),
    .btn_level_pe (btn_level_pe),
    .btn_timer_pe (btn_timer_pe),
    .duty         (duty),
    .level        (level),
    .timer_sel    (timer_sel),
    .remaining_s  (remaining_s),
    .ramping      (ramping)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drives one clock cycle of inputs, then returns 1 time unit after the edge.
  task automatic applyStimulus(input logic lvl, input logic tmr, input logic tck);
    btn_level_pe = lvl;
    btn_timer_pe = tmr;
    tick_1ms     = tck;
    @(posedge clk);
    #1;
    btn_level_pe = 1'b0;
    btn_timer_pe = 1'b0;
    tick_1ms     = 1'b0;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_duty"}, int'(duty), 0);
    checkOutput({tag, "_level"}, int'(level), 0);
    checkOutput({tag, "_timer_sel"}, int'(timer_sel), 0);
    checkOutput({tag, "_remaining"}, int'(remaining_s), 0);
    checkOutput({tag, "_ramping"}, int'(ramping), 0);
  endtask

  initial begin
    #3 reset_n = 1'b0;
    #2 checkAllZero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Ramp up from OFF to LOW
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("low_level", int'(level), 1);
    checkOutput("low_ramping_start", int'(ramping), 1);
    runTicks(3);
    checkOutput("low_duty_tick3", int'(duty), 0);
    runTicks(1);
    checkOutput("low_duty_tick4", int'(duty), 1);
    runTicks(95);
    checkOutput("low_duty_tick99", int'(duty), 24);
    checkOutput("low_ramping_tick99", int'(ramping), 1);
    runTicks(1);
    checkOutput("low_duty_tick100", int'(duty), 25);
    checkOutput("low_ramping_tick100", int'(ramping), 0);

    // MID ramp interrupted at 40 by HIGH with a partially counted prescaler
    applyStimulus(1'b1, 1'b0, 1'b0);
    runTicks(60);
    checkOutput("mid_duty_40", int'(duty), 40);
    runTicks(2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("high_level", int'(level), 3);
    checkOutput("high_duty_nojump", int'(duty), 40);
    checkOutput("high_ramping", int'(ramping), 1);
    runTicks(3);
    checkOutput("high_prescaler_cleared", int'(duty), 40);
    runTicks(1);
    checkOutput("high_duty_41", int'(duty), 41);
    runTicks(135);
    checkOutput("high_duty_74", int'(duty), 74);
    runTicks(1);
    checkOutput("high_duty_75", int'(duty), 75);
    checkOutput("high_ramping_done", int'(ramping), 0);

    // HIGH wraps to OFF and ramps down over 300 ticks
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("off_level", int'(level), 0);
    checkOutput("off_ramping", int'(ramping), 1);
    runTicks(299);
    checkOutput("off_duty_1", int'(duty), 1);
    runTicks(1);
    checkOutput("off_duty_0", int'(duty), 0);
    checkOutput("off_ramping_done", int'(ramping), 0);

    // Timer press is ignored while OFF
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("off_timer_ignored", int'(timer_sel), 0);
    checkOutput("off_remaining_ignored", int'(remaining_s), 0);

    // Coincident presses: level wins, timer dropped
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("both_level", int'(level), 1);
    checkOutput("both_timer_dropped", int'(timer_sel), 0);

    // MID with T1 countdown at 10 ticks per second
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("cd_level_mid", int'(level), 2);
    checkOutput("cd_timer_sel", int'(timer_sel), 1);
    checkOutput("cd_rem_3", int'(remaining_s), 3);
    runTicks(9);
    checkOutput("cd_rem_3_tick9", int'(remaining_s), 3);
    runTicks(1);
    checkOutput("cd_rem_2", int'(remaining_s), 2);
    runTicks(10);
    checkOutput("cd_rem_1", int'(remaining_s), 1);
    runTicks(9);
    checkOutput("cd_level_before_expiry", int'(level), 2);
    runTicks(1);
    checkOutput("cd_rem_0", int'(remaining_s), 0);
    checkOutput("cd_level_off", int'(level), 0);
    checkOutput("cd_timer_cleared", int'(timer_sel), 0);
    checkOutput("cd_duty_at_expiry", int'(duty), 7);
    checkOutput("cd_ramping_down", int'(ramping), 1);
    runTicks(27);
    checkOutput("cd_duty_1", int'(duty), 1);
    runTicks(1);
    checkOutput("cd_duty_0", int'(duty), 0);
    checkOutput("cd_ramping_done", int'(ramping), 0);

    // Preset cycling loads each preset, wrapping back to none
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("cyc_rem_t1", int'(remaining_s), 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("cyc_rem_t2", int'(remaining_s), 180);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("cyc_sel_t3", int'(timer_sel), 3);
    checkOutput("cyc_rem_t3", int'(remaining_s), 300);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("cyc_sel_none", int'(timer_sel), 0);
    checkOutput("cyc_rem_none", int'(remaining_s), 0);

    // Expiry coinciding with a level press: expiry wins
    applyStimulus(1'b0, 1'b1, 1'b0);
    runTicks(29);
    checkOutput("coinc_rem_1", int'(remaining_s), 1);
    checkOutput("coinc_level_low", int'(level), 1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("coinc_level_off", int'(level), 0);
    checkOutput("coinc_timer_sel", int'(timer_sel), 0);
    checkOutput("coinc_rem_0", int'(remaining_s), 0);

    // Asynchronous reset in the middle of a countdown
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    runTicks(12);
    checkOutput("mid_cd_rem_2", int'(remaining_s), 2);
    #2 reset_n = 1'b0;
    #1 checkAllZero("async_reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    runTicks(8);
    checkAllZero("post_reset_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
